vme_bus_env_mealy: RTL and testbench

- Synchronous Mealy environment for the event-encoded VME bus controller, i.e. the other end of its protocol.
- Bus-master side: issues dsr/dsw request events on command and waits for dtack events.
- Device side: answers lds events with ldtack events after a programmable latency.
- Used as a closed-loop stimulus/checker around the multi-FSM controller. All events are one-cycle pulses.

---
 rtl/vme_bus_env_mealy.sv | 220 ++++++++++++++++++++++
 tb/tb_vme_bus_env_mealy.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vme_bus_env_mealy.sv
// Closed-loop Mealy environment for the event-encoded VME bus controller:
// a bus-master requester plus a device that answers lds with ldtack.
module vme_bus_env_mealy #(
  parameter int unsigned LDTACK_DLY = 2,
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_write,
  output logic             req_ready,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic             dsr_PLUS,
  output logic             dsr_MINUS,
  output logic             dsw_PLUS,
  output logic             dsw_MINUS,
  output logic             ldtack_PLUS,
  output logic             ldtack_PLUSa,
  output logic             ldtack_MINUS,
  output logic             d_MINUSa,
  input  logic             d_PLUS,
  input  logic             d_PLUSa,
  input  logic             d_MINUS,
  input  logic             lds_PLUS,
  input  logic             lds_MINUS,
  input  logic             lds_MINUSa,
  input  logic             dtack_PLUS,
  input  logic             dtack_PLUSa,
  input  logic             dtack_MINUS
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned DW = $clog2(LDTACK_DLY + 1);

  typedef enum logic [1:0] {M_IDLE, M_WAIT_ACK, M_WAIT_REL} mstate_e;
  typedef enum logic [1:0] {D_LDS_LO, D_DLY_UP, D_LDS_HI, D_DLY_DN} dstate_e;

  mstate_e          mstate_q, mstate_d;
  dstate_e          dstate_q, dstate_d;
  logic             wr_q, wr_d;
  logic             seen_dat_q, seen_dat_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             dsr_p_q, dsr_p_d, dsr_m_q, dsr_m_d;
  logic             dsw_p_q, dsw_p_d, dsw_m_q, dsw_m_d;
  logic             ldt_p_q, ldt_p_d, ldt_pa_q, ldt_pa_d, ldt_m_q, ldt_m_d;
  logic             dmina_q, dmina_d;
  logic             done_c, err_c;
  logic             dtk_up, lds_dn;

  assign dtk_up    = dtack_PLUS | dtack_PLUSa;
  assign lds_dn    = lds_MINUS | lds_MINUSa;
  assign req_ready = (mstate_q == M_IDLE) && (dstate_q == D_LDS_LO);

  always_comb begin
    mstate_d   = mstate_q;
    dstate_d   = dstate_q;
    wr_d       = wr_q;
    seen_dat_d = seen_dat_q;
    tcnt_d     = tcnt_q + 1'b1;
    dcnt_d     = dcnt_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    dsr_p_d    = 1'b0;
    dsr_m_d    = 1'b0;
    dsw_p_d    = 1'b0;
    dsw_m_d    = 1'b0;
    ldt_p_d    = 1'b0;
    ldt_pa_d   = 1'b0;
    ldt_m_d    = 1'b0;
    dmina_d    = d_MINUS & wr_q & (mstate_q != M_IDLE);
    done_c     = 1'b0;
    err_c      = 1'b0;

    unique case (mstate_q)
      M_IDLE: begin
        tcnt_d = '0;
        if (dtk_up | dtack_MINUS) err_c = 1'b1;
        if (req_valid && req_ready) begin
          wr_d       = req_write;
          seen_dat_d = 1'b0;
          dsw_p_d    = req_write;
          dsr_p_d    = ~req_write;
          mstate_d   = M_WAIT_ACK;
        end
      end
      M_WAIT_ACK: begin
        // d_PLUS arriving together with dtack_PLUS still qualifies the read
        seen_dat_d = seen_dat_q | d_PLUS | d_PLUSa;
        if (dtack_MINUS) err_c = 1'b1;
        if (tcnt_q == TW'(TIMEOUT)) begin
          err_c    = 1'b1;
          mstate_d = M_IDLE;
          tcnt_d   = '0;
        end else if (dtk_up) begin
          if (!wr_q && !seen_dat_d) begin
            err_c = 1'b1;
          end else begin
            dsw_m_d  = wr_q;
            dsr_m_d  = ~wr_q;
            mstate_d = M_WAIT_REL;
            tcnt_d   = '0;
          end
        end
      end
      M_WAIT_REL: begin
        if (tcnt_q == TW'(TIMEOUT)) begin
          err_c    = 1'b1;
          mstate_d = M_IDLE;
          tcnt_d   = '0;
        end else if (dtack_MINUS) begin
          done_c   = 1'b1;
          mstate_d = M_IDLE;
          tcnt_d   = '0;
          if (wr_q) wr_cnt_d = wr_cnt_q + 1'b1;
          else      rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: mstate_d = M_IDLE;
    endcase

    if (lds_PLUS && dstate_q != D_LDS_LO) err_c = 1'b1;
    if (lds_dn && dstate_q != D_LDS_HI)   err_c = 1'b1;

    // A one-cycle latency answers straight from the idle/high state.
    unique case (dstate_q)
      D_LDS_LO: if (lds_PLUS) begin
        if (LDTACK_DLY <= 1) begin
          ldt_p_d  = ~wr_q;
          ldt_pa_d = wr_q;
          dstate_d = D_LDS_HI;
        end else begin
          dcnt_d   = DW'(LDTACK_DLY - 1);
          dstate_d = D_DLY_UP;
        end
      end
      D_DLY_UP: begin
        if (dcnt_q == DW'(1)) begin
          ldt_p_d  = ~wr_q;
          ldt_pa_d = wr_q;
          dstate_d = D_LDS_HI;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      D_LDS_HI: if (lds_dn) begin
        if (LDTACK_DLY <= 1) begin
          ldt_m_d  = 1'b1;
          dstate_d = D_LDS_LO;
        end else begin
          dcnt_d   = DW'(LDTACK_DLY - 1);
          dstate_d = D_DLY_DN;
        end
      end
      D_DLY_DN: begin
        if (dcnt_q == DW'(1)) begin
          ldt_m_d  = 1'b1;
          dstate_d = D_LDS_LO;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstate_q   <= M_IDLE;
      dstate_q   <= D_LDS_LO;
      wr_q       <= 1'b0;
      seen_dat_q <= 1'b0;
      tcnt_q     <= '0;
      dcnt_q     <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      dsr_p_q    <= 1'b0;
      dsr_m_q    <= 1'b0;
      dsw_p_q    <= 1'b0;
      dsw_m_q    <= 1'b0;
      ldt_p_q    <= 1'b0;
      ldt_pa_q   <= 1'b0;
      ldt_m_q    <= 1'b0;
      dmina_q    <= 1'b0;
    end else begin
      mstate_q   <= mstate_d;
      dstate_q   <= dstate_d;
      wr_q       <= wr_d;
      seen_dat_q <= seen_dat_d;
      tcnt_q     <= tcnt_d;
      dcnt_q     <= dcnt_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      dsr_p_q    <= dsr_p_d;
      dsr_m_q    <= dsr_m_d;
      dsw_p_q    <= dsw_p_d;
      dsw_m_q    <= dsw_m_d;
      ldt_p_q    <= ldt_p_d;
      ldt_pa_q   <= ldt_pa_d;
      ldt_m_q    <= ldt_m_d;
      dmina_q    <= dmina_d;
    end
  end

  assign done         = done_c & reset;
  assign err          = err_c & reset;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign dsr_PLUS     = dsr_p_q;
  assign dsr_MINUS    = dsr_m_q;
  assign dsw_PLUS     = dsw_p_q;
  assign dsw_MINUS    = dsw_m_q;
  assign ldtack_PLUS  = ldt_p_q;
  assign ldtack_PLUSa = ldt_pa_q;
  assign ldtack_MINUS = ldt_m_q;
  assign d_MINUSa     = dmina_q;
endmodule

// File: tb/tb_vme_bus_env_mealy.sv
// Randomized bench for vme_bus_env_mealy against a timestamp-based reference model.
module tb_vme_bus_env_mealy;
  localparam int unsigned DLY = 2;
  localparam int unsigned TMO = 64;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 3;
  localparam int unsigned SCH = 256;

  localparam logic [10:0] RV  = 11'h001, RW  = 11'h002, DP  = 11'h004, DPA = 11'h008;
  localparam logic [10:0] DM  = 11'h010, LP  = 11'h020, LM  = 11'h040, LMA = 11'h080;
  localparam logic [10:0] TP  = 11'h100, TPA = 11'h200, TM  = 11'h400;
  localparam int E_DSRP = 0, E_DSRM = 1, E_DSWP = 2, E_DSWM = 3;
  localparam int E_LTP = 4, E_LTPA = 5, E_LTM = 6, E_DMA = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic req_valid, req_write, d_PLUS, d_PLUSa, d_MINUS;
  logic lds_PLUS, lds_MINUS, lds_MINUSa, dtack_PLUS, dtack_PLUSa, dtack_MINUS;
  logic req_ready, done, err;
  logic [CW-1:0] rd_count, wr_count;
  logic [7:0] ev;
  logic s_ready, s_done, s_err;
  logic [CWS-1:0] s_rd, s_wr;
  logic [7:0] s_ev;

  vme_bus_env_mealy #(.LDTACK_DLY(DLY), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_ready(req_ready), .done(done), .err(err), .rd_count(rd_count), .wr_count(wr_count),
    .dsr_PLUS(ev[E_DSRP]), .dsr_MINUS(ev[E_DSRM]), .dsw_PLUS(ev[E_DSWP]), .dsw_MINUS(ev[E_DSWM]),
    .ldtack_PLUS(ev[E_LTP]), .ldtack_PLUSa(ev[E_LTPA]), .ldtack_MINUS(ev[E_LTM]),
    .d_MINUSa(ev[E_DMA]), .d_PLUS(d_PLUS), .d_PLUSa(d_PLUSa), .d_MINUS(d_MINUS),
    .lds_PLUS(lds_PLUS), .lds_MINUS(lds_MINUS), .lds_MINUSa(lds_MINUSa),
    .dtack_PLUS(dtack_PLUS), .dtack_PLUSa(dtack_PLUSa), .dtack_MINUS(dtack_MINUS));

  // Narrow-counter copy so counter wrap is reached within a short run.
  vme_bus_env_mealy #(.LDTACK_DLY(DLY), .TIMEOUT(TMO), .CNT_W(CWS)) dut_w (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_ready(s_ready), .done(s_done), .err(s_err), .rd_count(s_rd), .wr_count(s_wr),
    .dsr_PLUS(s_ev[E_DSRP]), .dsr_MINUS(s_ev[E_DSRM]), .dsw_PLUS(s_ev[E_DSWP]), .dsw_MINUS(s_ev[E_DSWM]),
    .ldtack_PLUS(s_ev[E_LTP]), .ldtack_PLUSa(s_ev[E_LTPA]), .ldtack_MINUS(s_ev[E_LTM]),
    .d_MINUSa(s_ev[E_DMA]), .d_PLUS(d_PLUS), .d_PLUSa(d_PLUSa), .d_MINUS(d_MINUS),
    .lds_PLUS(lds_PLUS), .lds_MINUS(lds_MINUS), .lds_MINUSa(lds_MINUSa),
    .dtack_PLUS(dtack_PLUS), .dtack_PLUSa(dtack_PLUSa), .dtack_MINUS(dtack_MINUS));

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned now = 0;

  // Reference model: master transaction flags, device busy-until timestamp,
  // and a table of output pulses scheduled for future cycles.
  bit m_busy, m_rel, m_wr, m_seen, d_hi;
  int unsigned m_entry, d_until, n_rd, n_wr;
  logic [7:0] sched [SCH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, now, got, exp);
    end
  endtask

  function automatic bit dev_lo();
    return !d_hi && now >= d_until;
  endfunction

  function automatic bit dev_up();
    return d_hi && now >= d_until;
  endfunction

  task automatic model_clear();
    m_busy = 0; m_rel = 0; m_wr = 0; m_seen = 0; d_hi = 0;
    m_entry = 0; d_until = 0; n_rd = 0; n_wr = 0;
    for (int i = 0; i < SCH; i++) sched[i] = '0;
  endtask

  task automatic step(input logic [10:0] v);
    logic [7:0] e_ev;
    bit e_err, e_done, lo, hi, rdy, wr_old;
    int unsigned rd0, wr0;
    {dtack_MINUS, dtack_PLUSa, dtack_PLUS, lds_MINUSa, lds_MINUS, lds_PLUS,
     d_MINUS, d_PLUSa, d_PLUS, req_write, req_valid} = v;
    e_ev = sched[now % SCH];
    sched[now % SCH] = '0;
    lo = dev_lo(); hi = dev_up();
    rdy = !m_busy && lo;
    rd0 = n_rd; wr0 = n_wr; wr_old = m_wr;
    e_err = 0; e_done = 0;

    if (!m_busy) begin
      if ((v & (TP | TPA | TM)) != 0) e_err = 1;
      if (v[0] && rdy) begin
        m_busy = 1; m_rel = 0; m_wr = v[1]; m_seen = 0; m_entry = now + 1;
        sched[(now + 1) % SCH][m_wr ? E_DSWP : E_DSRP] = 1'b1;
      end
    end else begin
      if (m_wr && (v & DM) != 0) sched[(now + 1) % SCH][E_DMA] = 1'b1;
      if (!m_rel) begin
        if ((v & (DP | DPA)) != 0) m_seen = 1;
        if ((v & TM) != 0) e_err = 1;
        if (now - m_entry == TMO) begin
          e_err = 1; m_busy = 0;
        end else if ((v & (TP | TPA)) != 0) begin
          if (!m_wr && !m_seen) e_err = 1;
          else begin
            m_rel = 1; m_entry = now + 1;
            sched[(now + 1) % SCH][m_wr ? E_DSWM : E_DSRM] = 1'b1;
          end
        end
      end else begin
        if (now - m_entry == TMO) begin
          e_err = 1; m_busy = 0;
        end else if ((v & TM) != 0) begin
          e_done = 1; m_busy = 0;
          if (m_wr) n_wr++; else n_rd++;
        end
      end
    end

    if ((v & LP) != 0) begin
      if (!lo) e_err = 1;
      else begin
        d_hi = 1; d_until = now + DLY;
        sched[(now + DLY) % SCH][((DLY == 1) ? wr_old : m_wr) ? E_LTPA : E_LTP] = 1'b1;
      end
    end
    if ((v & (LM | LMA)) != 0) begin
      if (!hi) e_err = 1;
      else begin
        d_hi = 0; d_until = now + DLY;
        sched[(now + DLY) % SCH][E_LTM] = 1'b1;
      end
    end

    @(negedge clk);
    check_eq("req_ready", 32'(req_ready), 32'(rdy));
    check_eq("events", 32'(ev), 32'(e_ev));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("err", 32'(err), 32'(e_err));
    check_eq("rd_count", 32'(rd_count), rd0 % (1 << CW));
    check_eq("wr_count", 32'(wr_count), wr0 % (1 << CW));
    check_eq("rd_count_wrap", 32'(s_rd), rd0 % (1 << CWS));
    check_eq("wr_count_wrap", 32'(s_wr), wr0 % (1 << CWS));
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic apply_reset();
    #2 reset = 1'b0;
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_events", 32'(ev), 32'd0);
    check_eq("rst_done_err", 32'({done, err}), 32'd0);
    check_eq("rst_counts", 32'({rd_count, wr_count}), 32'd0);
    {dtack_MINUS, dtack_PLUSa, dtack_PLUS, lds_MINUSa, lds_MINUS, lds_PLUS,
     d_MINUS, d_PLUSa, d_PLUS, req_write, req_valid} = '0;
    model_clear();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    now++;
  endtask

  function automatic logic [10:0] rand_vec();
    logic [10:0] v;
    int unsigned r;
    v = '0;
    r = $urandom_range(0, 99);
    if (!m_busy) begin
      if (r < 40) v = v | RV | ($urandom_range(0, 1) != 0 ? RW : 11'h000);
    end else if (!m_rel) begin
      if (r < 20) v = v | DP;
      else if (r < 30) v = v | DPA;
      else if (r < 45) v = v | ($urandom_range(0, 1) != 0 ? TP : TPA);
      if ($urandom_range(0, 9) == 0) v = v | DM;
    end else if (r < 30) begin
      v = v | TM;
    end
    if (dev_lo() && m_busy && $urandom_range(0, 99) < 30) v = v | LP;
    if (dev_up() && $urandom_range(0, 99) < 30) v = v | ($urandom_range(0, 1) != 0 ? LM : LMA);
    if ($urandom_range(0, 49) == 0) v = v | (11'(1) << $urandom_range(2, 10));
    return v;
  endfunction

  initial begin
    reset = 1'b0;
    {dtack_MINUS, dtack_PLUSa, dtack_PLUS, lds_MINUSa, lds_MINUS, lds_PLUS,
     d_MINUS, d_PLUSa, d_PLUS, req_write, req_valid} = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // read cycle
    step(RV); step(0); step(0); step(LP); step(0); step(0); step(0);
    step(DP); step(TP); step(0); step(LM); step(TM); step(0); step(0);
    // write cycle with data release
    step(RV | RW); step(0); step(LP); step(0); step(0); step(DM); step(0);
    step(TPA); step(0); step(LM); step(TM); step(0); step(0); step(0);
    // read acknowledged before any data strobe
    step(RV); step(0); step(TP); step(DP); step(TP); step(0); step(TM); step(0);
    // master timeout
    step(RV);
    for (int i = 0; i < 70; i++) step(0);
    // lds_MINUS while the rising delay is running
    step(LP); step(LM); step(0); step(LM); step(0); step(0); step(0);
    // err and done together, then several err sources at once
    step(RV); step(0); step(DP | TP); step(0); step(TM | LM); step(TP | LMA); step(0);
    // reset while waiting for release
    step(RV); step(0); step(DP); step(TP); step(0);
    apply_reset();

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      step(rand_vec());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
